// File: rtl/i2c_sequencer_pkg.sv
// Shared state encoding and default sizing for the I2C transaction sequencer.
package i2c_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_REGISTER_WIDTH = 8;
    localparam int DEFAULT_ADDRESS_WIDTH  = 7;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
    localparam int DIVIDER_WIDTH          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        RESPOND
    } seq_state_e;

endpackage

// File: rtl/i2c_transaction_sequencer.sv
// Accepts one register-level I2C command, launches the external master, waits for its
// busy window (with per-phase timeout) and returns a single response.
module i2c_transaction_sequencer
    import i2c_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      command_valid,
    output logic                      command_ready,
    input  logic                      command_read_write,
    input  logic [ADDRESS_WIDTH-1:0]  command_device_address,
    input  logic [REGISTER_WIDTH-1:0] command_register_address,
    input  logic [DATA_WIDTH-1:0]     command_data,
    input  logic [DIVIDER_WIDTH-1:0]  divider_config,
    output logic                      response_valid,
    input  logic                      response_ready,
    output logic [DATA_WIDTH-1:0]     response_data,
    output logic                      response_error,
    output logic                      master_enable,
    output logic                      master_read_write,
    output logic [DATA_WIDTH-1:0]     master_mosi_data,
    output logic [REGISTER_WIDTH-1:0] master_register_address,
    output logic [ADDRESS_WIDTH-1:0]  master_device_address,
    output logic [DIVIDER_WIDTH-1:0]  master_divider,
    input  logic [DATA_WIDTH-1:0]     master_miso_data,
    input  logic                      master_busy
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] EXPIRE_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_e                state_q,    state_d;
    logic                      rw_q,       rw_d;
    logic [ADDRESS_WIDTH-1:0]  dev_q,      dev_d;
    logic [REGISTER_WIDTH-1:0] reg_q,      reg_d;
    logic [DATA_WIDTH-1:0]     wdata_q,    wdata_d;
    logic [DIVIDER_WIDTH-1:0]  div_q,      div_d;
    logic [CNT_WIDTH-1:0]      cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                      rsp_err_q,  rsp_err_d;

    logic                      accept;
    logic [CNT_WIDTH-1:0]      cnt_inc;
    logic                      timeout_hit;

    assign command_ready = (state_q == IDLE) && !master_busy;
    assign accept        = command_valid && command_ready;

    // Saturating increment; expiry is judged on the value the counter is about to reach.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign timeout_hit = (cnt_inc >= EXPIRE_COUNT);

    always_comb begin
        // NOTE: every _d takes its _q value first so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rw_d    = command_read_write;
                    dev_d   = command_device_address;
                    reg_d   = command_register_address;
                    wdata_d = command_data;
                    div_d   = divider_config;
                    state_d = LAUNCH;
                end
            end

            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end

            WAIT_START: begin
                cnt_d = cnt_inc;
                if (master_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESPOND;
                end
            end

            WAIT_DONE: begin
                cnt_d = cnt_inc;
                // The awaited busy level is checked first so it wins over a coincident expiry.
                if (!master_busy) begin
                    rsp_data_d = rw_q ? master_miso_data : '0;
                    rsp_err_d  = 1'b0;
                    state_d    = RESPOND;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESPOND;
                end
            end

            RESPOND: begin
                if (response_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign master_enable           = (state_q == LAUNCH);
    assign master_read_write       = rw_q;
    assign master_device_address   = dev_q;
    assign master_register_address = reg_q;
    assign master_mosi_data        = wdata_q;
    assign master_divider          = div_q;

    assign response_valid = (state_q == RESPOND);
    assign response_data  = rsp_data_q;
    assign response_error = rsp_err_q;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Self-checking bench: instance A uses the default timeout, instance T a 16-cycle timeout
// for the expiry corner cases; a procedural model plays the I2C master.
module tb_i2c_transaction_sequencer;

    localparam int DW = 8;
    localparam int RW = 8;
    localparam int AW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_rw;
    logic [AW-1:0] cmd_dev;
    logic [RW-1:0] cmd_reg;
    logic [DW-1:0] cmd_data;
    logic [15:0]   div_cfg;
    logic [DW-1:0] miso;
    logic          rsp_ready;
    logic          valid_a, valid_t, busy_a, busy_t;
    logic          sel;

    logic a_ready, a_valid, a_err, a_en, a_rw;
    logic [DW-1:0] a_data, a_mosi;
    logic [RW-1:0] a_reg;
    logic [AW-1:0] a_dev;
    logic [15:0]   a_div;
    logic t_ready, t_valid, t_err, t_en, t_rw;
    logic [DW-1:0] t_data, t_mosi;
    logic [RW-1:0] t_reg;
    logic [AW-1:0] t_dev;
    logic [15:0]   t_div;

    i2c_transaction_sequencer dut_a (
        .clock(clk), .reset(rst),
        .command_valid(valid_a), .command_ready(a_ready),
        .command_read_write(cmd_rw), .command_device_address(cmd_dev),
        .command_register_address(cmd_reg), .command_data(cmd_data),
        .divider_config(div_cfg),
        .response_valid(a_valid), .response_ready(rsp_ready),
        .response_data(a_data), .response_error(a_err),
        .master_enable(a_en), .master_read_write(a_rw),
        .master_mosi_data(a_mosi), .master_register_address(a_reg),
        .master_device_address(a_dev), .master_divider(a_div),
        .master_miso_data(miso), .master_busy(busy_a)
    );

    i2c_transaction_sequencer #(.TIMEOUT_CYCLES(16)) dut_t (
        .clock(clk), .reset(rst),
        .command_valid(valid_t), .command_ready(t_ready),
        .command_read_write(cmd_rw), .command_device_address(cmd_dev),
        .command_register_address(cmd_reg), .command_data(cmd_data),
        .divider_config(div_cfg),
        .response_valid(t_valid), .response_ready(rsp_ready),
        .response_data(t_data), .response_error(t_err),
        .master_enable(t_en), .master_read_write(t_rw),
        .master_mosi_data(t_mosi), .master_register_address(t_reg),
        .master_device_address(t_dev), .master_divider(t_div),
        .master_miso_data(miso), .master_busy(busy_t)
    );

    logic o_ready, o_valid, o_err, o_en, o_rw;
    logic [DW-1:0] o_data, o_mosi;
    logic [RW-1:0] o_reg;
    logic [AW-1:0] o_dev;
    logic [15:0]   o_div;

    assign o_ready = sel ? t_ready : a_ready;
    assign o_valid = sel ? t_valid : a_valid;
    assign o_err   = sel ? t_err   : a_err;
    assign o_en    = sel ? t_en    : a_en;
    assign o_rw    = sel ? t_rw    : a_rw;
    assign o_data  = sel ? t_data  : a_data;
    assign o_mosi  = sel ? t_mosi  : a_mosi;
    assign o_reg   = sel ? t_reg   : a_reg;
    assign o_dev   = sel ? t_dev   : a_dev;
    assign o_div   = sel ? t_div   : a_div;

    typedef struct {
        logic          sel;        // 0: default timeout, 1: 16-cycle timeout
        logic          rw;
        logic [AW-1:0] dev;
        logic [RW-1:0] rg;
        logic [DW-1:0] wdata;
        logic [15:0]   div;
        logic [DW-1:0] miso;
        int            start_dly;  // cycles after the enable cycle before busy rises
        int            busy_len;   // 0: busy never rises
        int            hold;       // cycles response_ready stays low in RESPOND
        int            exp_lat;    // RESPOND cycle counted from acceptance
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    vec_t vecs[9];
    exp_t sb_q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_busy(input logic s, input logic b);
        if (s) busy_t = b;
        else   busy_a = b;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   k;
        bit   got;
        int   en_cnt;
        int   unstable;
        int   hold_bad;
        logic [DW-1:0] seen_data;
        logic          seen_err;

        sel      = v.sel;
        cmd_rw   = v.rw;
        cmd_dev  = v.dev;
        cmd_reg  = v.rg;
        cmd_data = v.wdata;
        div_cfg  = v.div;
        miso     = v.miso;
        if (v.sel) valid_t = 1'b1;
        else       valid_a = 1'b1;
        e.data = v.exp_data;
        e.err  = v.exp_err;
        sb_q.push_back(e);
        #1;
        check($sformatf("v%0d command_ready", idx), o_ready, 1);
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_t = 1'b0;
        // Scramble the command bus so the master_* outputs must come from holding registers.
        cmd_dev  = ~v.dev;
        cmd_reg  = ~v.rg;
        cmd_data = ~v.wdata;
        div_cfg  = ~v.div;
        cmd_rw   = ~v.rw;

        k = 0; got = 0; en_cnt = 0; unstable = 0;
        while (!got && k < 200) begin
            if (o_valid) begin
                got = 1;
            end else begin
                drive_busy(v.sel, (v.busy_len != 0) && (k >= v.start_dly) &&
                                  (k < v.start_dly + v.busy_len));
                if (o_en) en_cnt++;
                if (o_rw !== v.rw || o_dev !== v.dev || o_reg !== v.rg ||
                    o_mosi !== v.wdata || o_div !== v.div) unstable++;
                @(posedge clk); #1;
                k++;
            end
        end
        drive_busy(v.sel, 1'b0);

        check($sformatf("v%0d response seen", idx), 32'(got), 1);
        check($sformatf("v%0d enable pulses", idx), en_cnt, 1);
        check($sformatf("v%0d master fields", idx), unstable, 0);
        check($sformatf("v%0d latency", idx), k + 1, v.exp_lat);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("v%0d response_data", idx), o_data, e.data);
            check($sformatf("v%0d response_error", idx), o_err, e.err);
        end

        seen_data = o_data;
        seen_err  = o_err;
        hold_bad  = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b1 || o_data !== seen_data || o_err !== seen_err ||
                o_ready !== 1'b0) hold_bad++;
            if (o_rw !== v.rw || o_dev !== v.dev || o_mosi !== v.wdata) hold_bad++;
        end
        if (v.hold != 0)
            check($sformatf("v%0d backpressure hold", idx), hold_bad, 0);

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check($sformatf("v%0d valid after handshake", idx), o_valid, 0);
        check($sformatf("v%0d ready after handshake", idx), o_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        //           sel   rw    dev     reg     wdata   div        miso    dly len hold lat data   err
        vecs[0] = '{1'b0, 1'b0, 7'h11, 8'h05, 8'hA5, 16'h0004, 8'h77, 2,  20, 0,   24, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 7'h11, 8'h10, 8'h00, 16'h0004, 8'h3C, 2,  20, 0,   24, 8'h3C, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 7'h7F, 8'hFF, 8'h5A, 16'hBEEF, 8'hC3, 2,  20, 10,  24, 8'hC3, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 7'h00, 8'h00, 8'hFF, 16'h0001, 8'h5A, 1,  1,  0,   4,  8'h00, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 7'h2A, 8'h33, 8'h44, 16'h0010, 8'h99, 1,  0,  0,   17, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 7'h15, 8'h20, 8'h00, 16'h0010, 8'h6E, 1,  15, 0,   18, 8'h6E, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 7'h15, 8'h21, 8'h00, 16'h0010, 8'h6E, 1,  16, 0,   18, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 7'h16, 8'h22, 8'h00, 16'h0010, 8'h81, 15, 3,  0,   20, 8'h81, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 7'h16, 8'h23, 8'h00, 16'h0010, 8'h81, 16, 3,  0,   17, 8'h00, 1'b1};

        sel = 1'b0;
        rst = 1'b1;
        valid_a = 1'b0; valid_t = 1'b0;
        busy_a  = 1'b0; busy_t  = 1'b0;
        rsp_ready = 1'b0;
        cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_data = '0; div_cfg = '0; miso = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset command_ready", a_ready, 1);
        check("reset response_valid", a_valid, 0);
        check("reset master_enable", a_en, 0);
        check("reset response_error", a_err, 0);
        check("reset response_data", a_data, 0);
        check("reset master fields", {a_rw, a_dev, a_reg, a_mosi, a_div}, 0);
        check("reset t command_ready", t_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while the master is mid-transfer: no response, and commands stall until busy drops.
        sel = 1'b0;
        cmd_rw = 1'b1; cmd_dev = 7'h22; cmd_reg = 8'h33; cmd_data = 8'h00; div_cfg = 16'h0008;
        miso = 8'hAB;
        valid_a = 1'b1;
        #1;
        check("abort command_ready", a_ready, 1);
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(posedge clk); #1;
        busy_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort response_valid", a_valid, 0);
        check("abort command_ready", a_ready, 0);
        check("abort outputs cleared", {a_en, a_err, a_data, a_rw, a_dev, a_reg, a_div}, 0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (a_valid !== 1'b0 || a_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("abort stall while busy", bad, 0);
        busy_a = 1'b0;
        #1;
        check("abort ready after busy drops", a_ready, 1);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (a_valid !== 1'b0 || a_en !== 1'b0) bad++;
        end
        check("abort no late response", bad, 0);

        run_vec(9, vecs[1]);

        check("scoreboard drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/i2c_transaction_sequencer.md
I2C_TRANSACTION_SEQUENCER -- requirements
Module: i2c_transaction_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 8, data byte width.
- REGISTER_WIDTH, 8, register address width.
- ADDRESS_WIDTH, 7, device address width.
- TIMEOUT_CYCLES, 65535, maximum wait cycles per phase.

REQ-002 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.

REQ-003 Ports SHALL be, one per line:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- command_valid  in  1  command offered.
- command_ready  out  1  command accepted when high with valid.
- command_read_write  in  1  1=read, 0=write.
- command_device_address  in  ADDRESS_WIDTH  target device.
- command_register_address  in  REGISTER_WIDTH  target register.
- command_data  in  DATA_WIDTH  write byte.
- divider_config  in  16  I2C clock divider.
- response_valid  out  1  result available.
- response_ready  in  1  result consumed.
- response_data  out  DATA_WIDTH  read byte (0 for writes or errors).
- response_error  out  1  timeout flag.
- master_enable  out  1  start pulse to the I2C master.
- master_read_write  out  1  to the I2C master.
- master_mosi_data  out  DATA_WIDTH  to the I2C master.
- master_register_address  out  REGISTER_WIDTH  to the I2C master.
- master_device_address  out  ADDRESS_WIDTH  to the I2C master.
- master_divider  out  16  to the I2C master.
- master_miso_data  in  DATA_WIDTH  from the I2C master.
- master_busy  in  1  from the I2C master.

Function
REQ-004 The FSM SHALL have states IDLE, LAUNCH, WAIT_START, WAIT_DONE, RESPOND.

REQ-005 command_ready SHALL equal (state==IDLE) and not master_busy; no other state accepts commands.

REQ-006 On command_valid and command_ready in cycle N, all command fields and divider_config SHALL be registered, and the FSM SHALL enter LAUNCH in N+1.

REQ-007 In LAUNCH, master_enable SHALL be high for exactly one cycle (N+1), the timeout counter SHALL clear, and the next state SHALL be WAIT_START.

REQ-008 The master_* address, data, read_write and divider outputs SHALL be driven from the holding registers and SHALL stay stable from LAUNCH until return to IDLE.

REQ-009 In WAIT_START, master_busy=1 SHALL move the FSM to WAIT_DONE with the counter cleared.

REQ-010 In WAIT_DONE, master_busy=0 SHALL capture response_data from master_miso_data for reads (0 for writes), set response_error=0, and move the FSM to RESPOND.

REQ-011 In WAIT_START and WAIT_DONE, the counter SHALL increment each cycle; reaching TIMEOUT_CYCLES-1 without the awaited busy edge SHALL force RESPOND with response_error=1 and response_data=0.

REQ-012 If the awaited busy level and timeout expiry occur in the same cycle, the busy condition SHALL win (no error).

REQ-013 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, unsigned, and SHALL saturate rather than wrap.

REQ-014 In RESPOND, response_valid SHALL be high and response_data and response_error SHALL be held until response_ready is high; the FSM SHALL then enter IDLE in the next cycle.

REQ-015 Back-to-back operation: a new command SHALL be acceptable in the cycle after the response handshake, provided master_busy=0.

Reset
REQ-016 On reset, the FSM SHALL be in IDLE and master_enable, response_valid and response_error SHALL be 0.

REQ-017 On reset, response_data, all master_* outputs, the holding registers and the counter SHALL be 0.

REQ-018 Reset mid-transaction SHALL abort to IDLE with no response emitted; new commands SHALL stall via REQ-005 until the external master_busy drops.

Structure
REQ-019 A shared package i2c_sequencer_pkg SHALL hold the state enum typedef and the default width and timeout constants.

REQ-020 The block SHALL be a single module with no sub-module; the counter and FSM SHALL be inline.

Verification
REQ-021 Write, with a model master raising busy 2 cycles after enable for 20 cycles:
- Stimulus: rw=0, dev=0x11, reg=0x05, data=0xA5.
- Response: one enable pulse; master_* outputs match the command; response_valid with data=0x00, error=0.

REQ-022 Read, with the model returning 0x3C:
- Stimulus: rw=1, dev=0x11, reg=0x10.
- Response: response_data=0x3C, error=0.

REQ-023 Start timeout (TIMEOUT_CYCLES=16), busy never rises:
- Response: response_valid 17 cycles after acceptance, with error=1 and data=0.

REQ-024 Backpressure: response_ready held low for 10 cycles:
- Response: response_valid and response_data stable; command_ready=0 throughout.

REQ-025 Reset asserted in WAIT_DONE with busy still high:
- Response: no response emitted; command_ready stays 0 until busy falls, then goes to 1.

REQ-026 Busy falls in the same cycle the counter expires:
- Response: error=0 and data captured.
